// File: rtl/lc3_writeback_if.sv
// Bundle between the LC3 execute/memory stages and the writeback stage:
// write request, register read ports and the delayed writeback record.
interface lc3_writeback_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
);
  logic                      enable_writeback;
  logic [1:0]                W_Control_in;
  logic [DATA_WIDTH-1:0]     aluout;
  logic [DATA_WIDTH-1:0]     memout;
  logic [DATA_WIDTH-1:0]     pcout;
  logic [REG_ADDR_WIDTH-1:0] dr;
  logic [REG_ADDR_WIDTH-1:0] sr1;
  logic [REG_ADDR_WIDTH-1:0] sr2;
  logic [DATA_WIDTH-1:0]     d1;
  logic [DATA_WIDTH-1:0]     d2;
  logic [2:0]                psr;
  logic                      wb_valid_out;
  logic [REG_ADDR_WIDTH-1:0] wb_dr_out;
  logic [DATA_WIDTH-1:0]     wb_data_out;

  modport master (
    output enable_writeback, W_Control_in, aluout, memout, pcout, dr, sr1, sr2,
    input  d1, d2, psr, wb_valid_out, wb_dr_out, wb_data_out
  );

  modport slave (
    input  enable_writeback, W_Control_in, aluout, memout, pcout, dr, sr1, sr2,
    output d1, d2, psr, wb_valid_out, wb_dr_out, wb_data_out
  );
endinterface

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: result select, 8-entry register file, NZP condition
// codes and a one-cycle-delayed record of each accepted write.
module lc3_writeback #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic           clock,
  input  logic           reset,
  lc3_writeback_if.slave wb
);
  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'd0,
    SEL_MEM  = 2'd1,
    SEL_PC   = 2'd2,
    SEL_RSVD = 2'd3
  } wb_sel_e;

  wb_sel_e                   sel;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic                      write_en;

  logic [DATA_WIDTH-1:0]     regs_q [NUM_REGS];
  logic [2:0]                psr_q, psr_d;
  logic                      wb_valid_q, wb_valid_d;
  logic [REG_ADDR_WIDTH-1:0] wb_dr_q, wb_dr_d;
  logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;

  assign sel = wb_sel_e'(wb.W_Control_in);

  // Enable gates first so an unknown select with no write cannot leak into state.
  assign write_en = wb.enable_writeback && (sel != SEL_RSVD);

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wb_data = wb.aluout;
    case (sel)
      SEL_MEM: wb_data = wb.memout;
      SEL_PC:  wb_data = wb.pcout;
      default: wb_data = wb.aluout;
    endcase
  end

  always_comb begin
    psr_d      = psr_q;
    wb_valid_d = write_en;
    wb_dr_d    = wb_dr_q;
    wb_data_d  = wb_data_q;
    if (write_en) begin
      if (wb_data[DATA_WIDTH-1])  psr_d = 3'b100;
      else if (wb_data == '0)     psr_d = 3'b010;
      else                        psr_d = 3'b001;
      wb_dr_d   = wb.dr;
      wb_data_d = wb_data;
    end
  end

  // NOTE: the register file is reset explicitly, so it maps to flops rather than a RAM macro;
  // reads after reset must return zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (write_en) begin
      // NOTE: non-blocking writes keep same-cycle reads returning the old value.
      regs_q[wb.dr] <= wb_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      psr_q      <= 3'b000;
      wb_valid_q <= 1'b0;
      wb_dr_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      psr_q      <= psr_d;
      wb_valid_q <= wb_valid_d;
      wb_dr_q    <= wb_dr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Read ports have no bypass; the execute stage resolves hazards.
  assign wb.d1           = regs_q[wb.sr1];
  assign wb.d2           = regs_q[wb.sr2];
  assign wb.psr          = psr_q;
  assign wb.wb_valid_out = wb_valid_q;
  assign wb.wb_dr_out    = wb_dr_q;
  assign wb.wb_data_out  = wb_data_q;
endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: directed vector table, hand-written
// corner sequences and randomized cycles against a register-array model.
module tb_lc3_writeback;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  lc3_writeback_if #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) bus ();

  lc3_writeback #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [1:0]  ctrl;
    logic [15:0] alu, mem, pc;
    logic [2:0]  dr, sr1, sr2;
    logic [15:0] exp_d1, exp_d2;
    logic [2:0]  exp_psr;
    logic        exp_valid;
    logic [2:0]  exp_dr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  // Reference model state
  logic [15:0] m_regs [8];
  logic [2:0]  m_psr;
  logic        m_valid;
  logic [2:0]  m_dr;
  logic [15:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] ctrl, input logic [15:0] alu,
                       input logic [15:0] mem, input logic [15:0] pc, input logic [2:0] dr,
                       input logic [2:0] sr1, input logic [2:0] sr2);
    bus.enable_writeback = en;
    bus.W_Control_in     = ctrl;
    bus.aluout           = alu;
    bus.memout           = mem;
    bus.pcout            = pc;
    bus.dr               = dr;
    bus.sr1              = sr1;
    bus.sr2              = sr2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [2:0] nzp(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  initial begin
    drive(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);

    vecs[0] = '{1'b1, 2'd0, 16'h8001, 16'h0000, 16'h0000, 3'd3, 3'd3, 3'd3,
                16'h8001, 16'h8001, 3'b100, 1'b1, 3'd3, 16'h8001};
    vecs[1] = '{1'b1, 2'd1, 16'h1234, 16'h0000, 16'h5555, 3'd5, 3'd5, 3'd3,
                16'h0000, 16'h8001, 3'b010, 1'b1, 3'd5, 16'h0000};
    vecs[2] = '{1'b1, 2'd2, 16'h1234, 16'h9999, 16'h3005, 3'd7, 3'd7, 3'd3,
                16'h3005, 16'h8001, 3'b001, 1'b1, 3'd7, 16'h3005};
    vecs[3] = '{1'b0, 2'd0, 16'hFFFF, 16'h0000, 16'h0000, 3'd3, 3'd3, 3'd3,
                16'h8001, 16'h8001, 3'b001, 1'b0, 3'd7, 16'h3005};
    vecs[4] = '{1'b1, 2'd3, 16'h1234, 16'hFFFF, 16'h0000, 3'd3, 3'd3, 3'd3,
                16'h8001, 16'h8001, 3'b001, 1'b0, 3'd7, 16'h3005};
    vecs[5] = '{1'b1, 2'd0, 16'h7FFF, 16'h0000, 16'h0000, 3'd0, 3'd0, 3'd5,
                16'h7FFF, 16'h0000, 3'b001, 1'b1, 3'd0, 16'h7FFF};
    vecs[6] = '{1'b1, 2'd1, 16'h0000, 16'h8000, 16'h0000, 3'd6, 3'd6, 3'd7,
                16'h8000, 16'h3005, 3'b100, 1'b1, 3'd6, 16'h8000};

    // Reset state: every read index returns zero
    #2;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        bus.sr1 = 3'(i);
        bus.sr2 = 3'(j);
        #1;
        check("reset_d1", 32'(bus.d1), 32'h0);
        check("reset_d2", 32'(bus.d2), 32'h0);
      end
    end
    check("reset_psr", 32'(bus.psr), 32'h0);
    check("reset_valid", 32'(bus.wb_valid_out), 32'h0);
    check("reset_wb_dr", 32'(bus.wb_dr_out), 32'h0);
    check("reset_wb_data", 32'(bus.wb_data_out), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Directed vector table
    for (int k = 0; k < 7; k++) begin
      drive(vecs[k].en, vecs[k].ctrl, vecs[k].alu, vecs[k].mem, vecs[k].pc,
            vecs[k].dr, vecs[k].sr1, vecs[k].sr2);
      tick();
      check($sformatf("vec%0d_d1", k), 32'(bus.d1), 32'(vecs[k].exp_d1));
      check($sformatf("vec%0d_d2", k), 32'(bus.d2), 32'(vecs[k].exp_d2));
      check($sformatf("vec%0d_psr", k), 32'(bus.psr), 32'(vecs[k].exp_psr));
      check($sformatf("vec%0d_valid", k), 32'(bus.wb_valid_out), 32'(vecs[k].exp_valid));
      check($sformatf("vec%0d_wb_dr", k), 32'(bus.wb_dr_out), 32'(vecs[k].exp_dr));
      check($sformatf("vec%0d_wb_data", k), 32'(bus.wb_data_out), 32'(vecs[k].exp_data));
    end

    // Same-cycle read of the register being written returns the old value
    drive(1'b1, 2'd0, 16'h0011, 16'h0, 16'h0, 3'd2, 3'd2, 3'd2);
    tick();
    drive(1'b1, 2'd0, 16'h0022, 16'h0, 16'h0, 3'd2, 3'd2, 3'd2);
    #1;
    check("same_cycle_old", 32'(bus.d1), 32'h0011);
    tick();
    check("same_cycle_new", 32'(bus.d1), 32'h0022);

    // Back-to-back writes to R4
    drive(1'b1, 2'd0, 16'h1111, 16'h0, 16'h0, 3'd4, 3'd4, 3'd4);
    tick();
    check("b2b_valid1", 32'(bus.wb_valid_out), 32'h1);
    check("b2b_d1_first", 32'(bus.d1), 32'h1111);
    drive(1'b1, 2'd0, 16'hF000, 16'h0, 16'h0, 3'd4, 3'd4, 3'd4);
    tick();
    check("b2b_valid2", 32'(bus.wb_valid_out), 32'h1);
    check("b2b_d1", 32'(bus.d1), 32'hF000);
    check("b2b_psr", 32'(bus.psr), 32'h4);
    check("b2b_wb_data", 32'(bus.wb_data_out), 32'hF000);

    // Asynchronous reset mid-cycle clears everything before the next edge
    drive(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd4, 3'd2);
    #2;
    reset = 1'b1;
    #1;
    check("areset_d1", 32'(bus.d1), 32'h0);
    check("areset_d2", 32'(bus.d2), 32'h0);
    check("areset_psr", 32'(bus.psr), 32'h0);
    check("areset_valid", 32'(bus.wb_valid_out), 32'h0);
    check("areset_wb_dr", 32'(bus.wb_dr_out), 32'h0);
    check("areset_wb_data", 32'(bus.wb_data_out), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    drive(1'b1, 2'd1, 16'h0, 16'h0005, 16'h0, 3'd1, 3'd1, 3'd4);
    tick();
    check("post_reset_d1", 32'(bus.d1), 32'h0005);
    check("post_reset_d2", 32'(bus.d2), 32'h0);
    check("post_reset_psr", 32'(bus.psr), 32'h1);
    check("post_reset_valid", 32'(bus.wb_valid_out), 32'h1);
    check("post_reset_wb_dr", 32'(bus.wb_dr_out), 32'h1);

    // Randomized cycles against the model, starting from a fresh reset
    drive(1'b0, 2'd0, 16'h0, 16'h0, 16'h0, 3'd0, 3'd0, 3'd0);
    do_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_psr = 3'b000; m_valid = 1'b0; m_dr = 3'd0; m_data = 16'h0;
    for (int n = 0; n < 300; n++) begin
      logic        en;
      logic [1:0]  ctrl;
      logic [15:0] vals [3];
      logic [2:0]  dr, s1, s2;
      logic [15:0] res;
      en   = ($urandom_range(0, 3) != 0);
      ctrl = 2'($urandom_range(0, 3));
      for (int v = 0; v < 3; v++) begin
        case ($urandom_range(0, 3))
          0:       vals[v] = 16'h0000;
          1:       vals[v] = 16'h8000 | 16'($urandom);
          default: vals[v] = 16'($urandom);
        endcase
      end
      dr = 3'($urandom_range(0, 7));
      s1 = 3'($urandom_range(0, 7));
      s2 = 3'($urandom_range(0, 7));
      drive(en, ctrl, vals[0], vals[1], vals[2], dr, s1, s2);
      #1;
      check("rnd_pre_d1", 32'(bus.d1), 32'(m_regs[s1]));
      check("rnd_pre_d2", 32'(bus.d2), 32'(m_regs[s2]));
      if (en && ctrl != 2'd3) begin
        res        = (ctrl == 2'd0) ? vals[0] : (ctrl == 2'd1) ? vals[1] : vals[2];
        m_regs[dr] = res;
        m_psr      = nzp(res);
        m_valid    = 1'b1;
        m_dr       = dr;
        m_data     = res;
      end else begin
        m_valid = 1'b0;
      end
      tick();
      check("rnd_psr", 32'(bus.psr), 32'(m_psr));
      check("rnd_valid", 32'(bus.wb_valid_out), 32'(m_valid));
      check("rnd_wb_dr", 32'(bus.wb_dr_out), 32'(m_dr));
      check("rnd_wb_data", 32'(bus.wb_data_out), 32'(m_data));
      check("rnd_post_d1", 32'(bus.d1), 32'(m_regs[s1]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lc3_writeback.md
Name: lc3_writeback

Overview:
- Writeback stage of the LC3 pipeline. It consumes the execute-stage output bundle (aluout, pcout, dr) and the memory-access read data (memout).
- Selects the result, writes it into the 8-entry general-purpose register file and updates the PSR condition codes (NZP).
- Supplies combinational register read data (d1/d2) back to the execute stage.
- Registers a one-cycle-delayed write record for the writeback monitor/scoreboard.

Parameters:
- DATA_WIDTH, 16, width of registers, datapath and result buses
- REG_ADDR_WIDTH, 3, register index width; register count = 2**REG_ADDR_WIDTH (8)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable_writeback  input  1  qualifies a write this cycle
- W_Control_in  input  2  result select: 0=aluout, 1=memout, 2=pcout, 3=reserved
- aluout  input  DATA_WIDTH  execute ALU/address result
- memout  input  DATA_WIDTH  memory read data
- pcout  input  DATA_WIDTH  PC-derived result (JSR/LEA path)
- dr  input  REG_ADDR_WIDTH  destination register index
- sr1  input  REG_ADDR_WIDTH  read port 1 index
- sr2  input  REG_ADDR_WIDTH  read port 2 index
- d1  output  DATA_WIDTH  R[sr1], combinational
- d2  output  DATA_WIDTH  R[sr2], combinational
- psr  output  3  condition codes {N,Z,P}, registered
- wb_valid_out  output  1  pulses one cycle after each accepted write
- wb_dr_out  output  REG_ADDR_WIDTH  index of last accepted write
- wb_data_out  output  DATA_WIDTH  data of last accepted write

Behaviour:
- Reset (asynchronous, takes effect immediately while high): R0..R7=0; psr=3'b000; wb_valid_out=0; wb_dr_out=0; wb_data_out=0. d1/d2 therefore read 0 during reset.
- Result mux (combinational): wb_data = aluout / memout / pcout for W_Control_in 0 / 1 / 2.
- Accepted write: enable_writeback=1 and W_Control_in!=3. On that rising edge:
  - R[dr] <= wb_data.
  - psr <= 3'b100 if wb_data[DATA_WIDTH-1]=1; else 3'b010 if wb_data==0; else 3'b001. Exactly one bit of psr is set after any accepted write.
  - wb_valid_out <= 1; wb_dr_out <= dr; wb_data_out <= wb_data.
- No write (enable_writeback=0, or W_Control_in=3 reserved):
  - Register file and psr hold.
  - wb_valid_out <= 0; wb_dr_out and wb_data_out hold.
- Latency:
  - Write visible on d1/d2 the cycle after the edge.
  - psr and wb_* outputs update at the same edge as the write.
- Same-cycle read/write: read of dr while it is being written returns the old value. No bypass; the execute stage handles hazards.
- R0 is an ordinary writable register (no hard-wired zero).
- No wrap/overflow concerns: data passes through unmodified. Only the sign bit and zero-detect feed psr.
- Reset asserted mid-sequence: all state is cleared immediately. After reset deasserts, the first edge with an accepted write proceeds normally; no pending writes are retained.
- Reset state of psr=000 is not a legal post-write value. The scoreboard treats it as "no write since reset".
- X on W_Control_in/dr while enable_writeback=0 must not corrupt state.

Test Plan:
- Reset, then read all sr1/sr2 combinations -> d1=d2=16'h0000 for every index; psr=000; wb_valid_out=0.
- Write cycles:
  - enable=1, W_Control=0, aluout=16'h8001, dr=3 -> next cycle R3=8001 (via sr1=3), psr=100, wb_valid_out=1, wb_dr_out=3, wb_data_out=8001.
  - W_Control=1, memout=16'h0000, dr=5 -> R5=0000, psr=010.
  - W_Control=2, pcout=16'h3005, dr=7 -> R7=3005, psr=001.
- Hold conditions:
  - enable=0, aluout=16'hFFFF, dr=3 -> R3 stays 8001, psr unchanged, wb_valid_out=0.
  - enable=1, W_Control=3 -> no state change.
- Same-cycle read/write: sr1=dr=2, R2=0011, write aluout=16'h0022 -> d1=0011 in write cycle, 0022 next cycle.
- Back-to-back writes to R4 (0x1111 then 0xF000 on consecutive cycles) -> R4=F000, psr=100, wb_valid_out high both cycles.
- Assert reset asynchronously mid-cycle after several writes -> d1/d2, psr and wb_* drop to 0 before the next clock edge. After release, the first write behaves normally.
